// File: rtl/package_param_streamer_if.sv
// Handshake bundle for package_param_streamer: start/ready controls in, beat stream and status out.
// The master modport is the streamer side; the slave modport is the consumer/controller side.
interface package_param_streamer_if;
    logic        start_i;
    logic        ready_i;
    logic        valid_o;
    logic [31:0] data_o;
    logic [3:0]  idx_o;
    logic        last_o;
    logic        busy_o;
    logic        done_o;
    logic [7:0]  beat_count_o;

    modport master (
        input  start_i, ready_i,
        output valid_o, data_o, idx_o, last_o, busy_o, done_o, beat_count_o
    );

    modport slave (
        output start_i, ready_i,
        input  valid_o, data_o, idx_o, last_o, busy_o, done_o, beat_count_o
    );
endinterface

// File: rtl/package_param_streamer.sv
// Serialises the test-package constants onto a 32-bit valid/ready stream, one beat per word.
// Optional macro PARAM_STREAM_CHECKSUM_EN appends an XOR checksum beat (NBEATS 10 -> 11).
module package_param_streamer #(
    parameter int          FIVE_INT          = 5,
    parameter logic [31:0] EIGHT_LOGIC       = 32'd8,
    parameter logic [63:0] LONG_PARAM        = 64'hFF,
    parameter logic [99:0] REALLY_LONG_PARAM = 100'hFF,
    parameter int          ELEVEN_INT        = 11,
    parameter int          UNIT_FOUR_INT     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    package_param_streamer_if.master  bus
);

    localparam logic [9:0][31:0] BASE = {
        32'(UNIT_FOUR_INT),
        32'(ELEVEN_INT),
        {28'b0, REALLY_LONG_PARAM[99:96]},
        REALLY_LONG_PARAM[95:64],
        REALLY_LONG_PARAM[63:32],
        REALLY_LONG_PARAM[31:0],
        LONG_PARAM[63:32],
        LONG_PARAM[31:0],
        EIGHT_LOGIC,
        32'(FIVE_INT)
    };

`ifdef PARAM_STREAM_CHECKSUM_EN
    localparam int NBEATS = 11;

    function automatic logic [31:0] xor_all(input logic [9:0][31:0] b);
        logic [31:0] acc;
        acc = '0;
        for (int i = 0; i < 10; i++) acc = acc ^ b[i];
        return acc;
    endfunction

    localparam logic [NBEATS-1:0][31:0] BEATS = {xor_all(BASE), BASE};
`else
    localparam int NBEATS = 10;
    localparam logic [NBEATS-1:0][31:0] BEATS = BASE;
`endif

    localparam logic [3:0] LAST_IDX = 4'(NBEATS - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [31:0] data_q, data_d;
    logic [7:0]  cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    // data is registered so the beat payload is stable for the whole valid window
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    state_d = STREAM;
                    idx_d   = '0;
                    data_d  = BEATS[0];
                end
            end
            STREAM: begin
                if (bus.ready_i) begin
                    cnt_d = cnt_q + 8'd1;
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d  = idx_q + 4'd1;
                        data_d = BEATS[idx_q + 4'd1];
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.valid_o      = (state_q == STREAM);
    assign bus.data_o       = data_q;
    assign bus.idx_o        = idx_q;
    assign bus.last_o       = (state_q == STREAM) && (idx_q == LAST_IDX);
    assign bus.busy_o       = (state_q != IDLE);
    assign bus.done_o       = (state_q == DONE);
    assign bus.beat_count_o = cnt_q;

endmodule

// File: tb/tb_package_param_streamer.sv
// Directed bench for package_param_streamer: scoreboard of expected beats checked on every accepted transfer.
// Build with PARAM_STREAM_CHECKSUM_EN to exercise the checksum beat.
module tb_package_param_streamer;

`ifdef PARAM_STREAM_CHECKSUM_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    typedef struct {
        logic [31:0] data;
        logic [3:0]  idx;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    package_param_streamer_if bus ();

    package_param_streamer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    beat_t       sb[$];
    logic [31:0] exp_tab [0:NB-1];
    logic [7:0]  exp_bc = '0;
    int          errors = 0;
    int          checks = 0;
    logic        stalled = 1'b0;
    logic [31:0] held_data;
    logic [3:0]  held_idx;
    logic        held_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_stream();
        for (int i = 0; i < NB; i++) begin
            beat_t b;
            b.data = exp_tab[i];
            b.idx  = 4'(i);
            b.last = (i == NB - 1);
            sb.push_back(b);
        end
        exp_bc = exp_bc + 8'(NB);
    endtask

    // Monitor at the falling edge, then advance to just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        if (!rst) begin
            if (stalled) begin
                chk("hold_data", bus.data_o, held_data);
                chk("hold_idx", 32'(bus.idx_o), 32'(held_idx));
                chk("hold_last", 32'(bus.last_o), 32'(held_last));
            end
            if (bus.valid_o && bus.ready_i) begin
                chk("beat_expected", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    beat_t b;
                    b = sb.pop_front();
                    chk("beat_data", bus.data_o, b.data);
                    chk("beat_idx", 32'(bus.idx_o), 32'(b.idx));
                    chk("beat_last", 32'(bus.last_o), 32'(b.last));
                end
            end
            stalled   = bus.valid_o && !bus.ready_i;
            held_data = bus.data_o;
            held_idx  = bus.idx_o;
            held_last = bus.last_o;
        end else begin
            stalled = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // Called in cycle 1 after the start edge; returns the cycle on which done_o is seen.
    task automatic run_until_done(input bit rnd, output int cyc);
        cyc = 1;
        while (!bus.done_o && cyc < 80) begin
            if (rnd) bus.ready_i = 1'($urandom_range(0, 1));
            tick();
            cyc++;
        end
        chk("stream_timeout", 32'(cyc < 80), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(bus.valid_o), 32'd0);
        chk({tag, "_data"}, bus.data_o, 32'd0);
        chk({tag, "_idx"}, 32'(bus.idx_o), 32'd0);
        chk({tag, "_last"}, 32'(bus.last_o), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
        chk({tag, "_done"}, 32'(bus.done_o), 32'd0);
        chk({tag, "_bc"}, 32'(bus.beat_count_o), 32'd0);
    endtask

    task automatic check_end(input string tag);
        chk({tag, "_bc"}, 32'(bus.beat_count_o), 32'(exp_bc));
        chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
        tick();
        chk({tag, "_done_pulse"}, 32'(bus.done_o), 32'd0);
        chk({tag, "_idle_busy"}, 32'(bus.busy_o), 32'd0);
        chk({tag, "_idle_valid"}, 32'(bus.valid_o), 32'd0);
    endtask

    initial begin
        int cyc;
        int g;
        exp_tab[0] = 32'd5;
        exp_tab[1] = 32'd8;
        exp_tab[2] = 32'hFF;
        exp_tab[3] = 32'h0;
        exp_tab[4] = 32'hFF;
        exp_tab[5] = 32'h0;
        exp_tab[6] = 32'h0;
        exp_tab[7] = 32'h0;
        exp_tab[8] = 32'd11;
        exp_tab[9] = 32'd4;
`ifdef PARAM_STREAM_CHECKSUM_EN
        exp_tab[10] = 32'h00000002;
`endif
        bus.start_i = 1'b0;
        bus.ready_i = 1'b0;

        // reset, then idle with start low
        tick();
        tick();
        rst = 1'b0;
        check_reset_outputs("reset");
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_valid", 32'(bus.valid_o), 32'd0);
            chk("idle_busy", 32'(bus.busy_o), 32'd0);
            chk("idle_done", 32'(bus.done_o), 32'd0);
            chk("idle_bc", 32'(bus.beat_count_o), 32'd0);
        end

        // full-rate stream
        bus.ready_i = 1'b1;
        bus.start_i = 1'b1;
        push_stream();
        tick();
        bus.start_i = 1'b0;
        chk("first_valid", 32'(bus.valid_o), 32'd1);
        chk("first_data", bus.data_o, 32'd5);
        chk("stream_busy", 32'(bus.busy_o), 32'd1);
        run_until_done(1'b0, cyc);
        chk("done_cycle", 32'(cyc), 32'(NB + 1));
        check_end("full");

        // random backpressure
        bus.start_i = 1'b1;
        push_stream();
        tick();
        bus.start_i = 1'b0;
        run_until_done(1'b1, cyc);
        check_end("bp");

        // starts during STREAM and DONE are ignored
        bus.ready_i = 1'b1;
        bus.start_i = 1'b1;
        push_stream();
        tick();
        bus.start_i = 1'b0;
        g = 0;
        while (!(bus.valid_o && bus.idx_o == 4'd3) && g < 40) begin
            tick();
            g++;
        end
        chk("reach_idx3", 32'(g < 40), 32'd1);
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        run_until_done(1'b0, cyc);
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        chk("ign_bc", 32'(bus.beat_count_o), 32'(exp_bc));
        chk("ign_sb_empty", 32'(sb.size()), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ign_valid", 32'(bus.valid_o), 32'd0);
            chk("ign_busy", 32'(bus.busy_o), 32'd0);
        end
        bus.start_i = 1'b1;
        push_stream();
        tick();
        bus.start_i = 1'b0;
        run_until_done(1'b0, cyc);
        check_end("second");

        // reset mid-stream abandons it
        bus.start_i = 1'b1;
        push_stream();
        tick();
        bus.start_i = 1'b0;
        g = 0;
        while (!(bus.valid_o && bus.idx_o == 4'd5) && g < 40) begin
            tick();
            g++;
        end
        chk("reach_idx5", 32'(g < 40), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        exp_bc = '0;
        check_reset_outputs("midrst");
        bus.start_i = 1'b1;
        push_stream();
        tick();
        bus.start_i = 1'b0;
        chk("restart_data", bus.data_o, 32'd5);
        chk("restart_idx", 32'(bus.idx_o), 32'd0);
        run_until_done(1'b0, cyc);
        chk("restart_done_cycle", 32'(cyc), 32'(NB + 1));
        check_end("restart");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/package_param_streamer.md
Name: package_param_streamer

Overview:
- Sequential stage that consumes the cocotb test-package constants and serialises them onto a 32-bit valid/ready stream.
- cocotb tests can then check constant values, including wide (>32-bit) ones, through a simulator-independent handshake interface instead of relying on hierarchical handle access.
- Sits directly downstream of the package definitions in the test_package testcase toplevel.

Parameters:
- FIVE_INT, 5, 32-bit signed int constant (beat 0)
- EIGHT_LOGIC, 32'd8, 32-bit logic constant (beat 1)
- LONG_PARAM, 64'hFF, 64-bit constant (beats 2-3)
- REALLY_LONG_PARAM, 100'hFF, 100-bit constant (beats 4-7)
- ELEVEN_INT, 11, 32-bit int constant (beat 8)
- UNIT_FOUR_INT, 4, 32-bit int constant from compilation-unit scope (beat 9)

Ports:
- clk  input  1  clock; all logic on the rising edge
- rst  input  1  synchronous, active-high reset
- start_i  input  1  request one full stream; sampled only in IDLE
- ready_i  input  1  downstream accepts data_o this cycle
- valid_o  output  1  data_o/idx_o/last_o valid
- data_o  output  32  current beat payload
- idx_o  output  4  current beat index, 0..NBEATS-1
- last_o  output  1  high on the final beat
- busy_o  output  1  high in STREAM and DONE
- done_o  output  1  one-cycle pulse after the final beat is accepted
- beat_count_o  output  8  total beats accepted since reset; wraps 255->0

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, valid_o=0, data_o=0, idx_o=0, last_o=0, busy_o=0, done_o=0, beat_count_o=0. Reset takes priority over every other event.
- Beat map (NBEATS=10):
  - beat 0: FIVE_INT
  - beat 1: EIGHT_LOGIC
  - beat 2: LONG_PARAM[31:0]
  - beat 3: LONG_PARAM[63:32]
  - beat 4: REALLY_LONG_PARAM[31:0]
  - beat 5: REALLY_LONG_PARAM[63:32]
  - beat 6: REALLY_LONG_PARAM[95:64]
  - beat 7: {28'b0, REALLY_LONG_PARAM[99:96]}
  - beat 8: ELEVEN_INT
  - beat 9: UNIT_FOUR_INT
  - Signed ints are passed as raw two's-complement bits, with no extension or truncation.
- FSM states: IDLE, STREAM, DONE.
  - IDLE: valid_o=0. If start_i=1 at an edge, go to STREAM with idx=0. valid_o=1 and data_o=beat 0 in the following cycle (1-cycle latency from start).
  - STREAM: valid_o=1. A transfer occurs when valid_o&&ready_i at an edge: beat_count_o increments.
    - If last_o=1 on the transfer, go to DONE with valid_o=0.
    - Otherwise idx increments and the next beat is presented the next cycle, with no bubble.
  - DONE: done_o=1 for exactly this cycle, then IDLE.
- Ready may drop at any time. While valid_o=1 and ready_i=0, data_o, idx_o and last_o hold stable (AXI-style: valid never depends on ready).
- Throughput with ready_i held at 1: beats on cycles 1..10 after start, done_o on cycle 11, IDLE on cycle 12.
- start_i in STREAM or DONE is ignored and not queued.
- busy_o = (state != IDLE).
- last_o = valid_o && (idx_o == NBEATS-1).
- data_o holds its last value when valid_o=0. This value is don't-care for checking.
- Reset asserted mid-stream abandons the stream. The next start_i restarts at beat 0.
- beat_count_o is cleared only by reset and counts across multiple streams.

Optional Feature:
- Macro: PARAM_STREAM_CHECKSUM_EN.
- When defined: NBEATS=11. Beat 10 = XOR of beats 0..9 (32-bit). last_o moves to beat 10. For the default parameters, beat 10 = 32'h00000002.
- When undefined: NBEATS=10, no checksum logic, and last_o is on beat 9.
- No port changes in either case.

Test Plan:
- Reset then idle, start_i=0 for 5 cycles -> valid_o=0, busy_o=0, done_o=0, beat_count_o=0 throughout.
- start_i pulse with ready_i=1 -> data_o = 5, 8, 0xFF, 0, 0xFF, 0, 0, 0, 11, 4 on idx 0..9, last_o only at idx 9, done_o on cycle 11, beat_count_o=10.
- ready_i random 50% backpressure -> same 10 values in order, data_o stable while stalled, no duplicates or drops.
- start_i re-pulsed at idx 3 and during DONE -> ignored; one stream only; a second start in IDLE yields beat_count_o=20.
- rst asserted at idx 5 -> next cycle all outputs at reset values; next start_i streams from beat 0 (value 5).
- With PARAM_STREAM_CHECKSUM_EN, ready_i=1 -> 11 beats, beat 10 = 0x00000002 with last_o=1, done_o on cycle 12.
